// File: rtl/mcdf_arb_pkg.sv
// Shared types and helpers for the MCDF packet arbiter.
package mcdf_arb_pkg;

  localparam int unsigned NCH    = 3;
  localparam int unsigned PRIO_W = 2;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ID_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  // Packet length in words for each len_sel code.
  function automatic logic [CNT_W-1:0] len_decode(input logic [1:0] sel);
    logic [CNT_W-1:0] len;
    case (sel)
      2'd0:    len = CNT_W'(4);
      2'd1:    len = CNT_W'(8);
      2'd2:    len = CNT_W'(16);
      default: len = CNT_W'(32);
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mcdf_arb_pick.sv
// Combinational channel selector: eligibility, lowest priority value, round-robin tie-break.
module mcdf_arb_pick
  import mcdf_arb_pkg::*;
(
  input  logic [NCH-1:0]        ch_en,
  input  logic [NCH*PRIO_W-1:0] ch_prio,
  input  logic [NCH*CNT_W-1:0]  ch_count,
  input  logic [CNT_W-1:0]      length,
  input  logic [ID_W-1:0]       last_gnt,
  output logic                  any_elig,
  output logic [ID_W-1:0]       pick_id
);

  logic [NCH-1:0]    elig;
  logic              found;
  logic [PRIO_W-1:0] best;
  logic [ID_W-1:0]   idx;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      elig[i] = ch_en[i] && (ch_count[i*CNT_W +: CNT_W] >= length);
    end
  end

  // Visit channels starting after last_gnt; strict '<' keeps the first tied channel.
  always_comb begin
    found   = 1'b0;
    best    = '0;
    idx     = '0;
    pick_id = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = ID_W'((32'(last_gnt) + 32'd1 + k) % NCH);
      if (elig[idx] && (!found || (ch_prio[idx*PRIO_W +: PRIO_W] < best))) begin
        found   = 1'b1;
        best    = ch_prio[idx*PRIO_W +: PRIO_W];
        pick_id = idx;
      end
    end
  end

  assign any_elig = |elig;

endmodule

// File: rtl/mcdf_pkt_arbiter.sv
// Packet arbiter: picks a channel, handshakes with the formatter, streams one framed packet.
module mcdf_pkt_arbiter
  import mcdf_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            ch_en,
  input  logic [NCH*PRIO_W-1:0]     ch_prio,
  input  logic [1:0]                len_sel,
  input  logic [NCH*CNT_W-1:0]      ch_count,
  input  logic [NCH*DATA_WIDTH-1:0] ch_data,
  output logic [NCH-1:0]            ch_rd,
  input  logic                      fmt_grant,
  output logic                      fmt_req,
  output logic [ID_W-1:0]           fmt_chid,
  output logic [CNT_W-1:0]          fmt_length,
  output logic                      fmt_valid,
  output logic [DATA_WIDTH-1:0]     fmt_data,
  output logic                      fmt_start,
  output logic                      fmt_end
);

  arb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [ID_W-1:0]       last_gnt_q, last_gnt_d;
  logic                  req_d, valid_d, start_d, end_d;
  logic [ID_W-1:0]       chid_d;
  logic [CNT_W-1:0]      len_d, next_len;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  any_elig, last_beat;
  logic [ID_W-1:0]       pick_id;

  assign next_len = len_decode(len_sel);

  mcdf_arb_pick u_pick (
    .ch_en    (ch_en),
    .ch_prio  (ch_prio),
    .ch_count (ch_count),
    .length   (next_len),
    .last_gnt (last_gnt_q),
    .any_elig (any_elig),
    .pick_id  (pick_id)
  );

  assign last_beat = (beat_q == (fmt_length - CNT_W'(1)));
  assign ch_rd     = (state_q == SEND) ? (NCH'(1) << fmt_chid) : '0;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      last_gnt_q <= ID_W'(2);
      fmt_req    <= 1'b0;
      fmt_chid   <= '0;
      fmt_length <= '0;
      fmt_valid  <= 1'b0;
      fmt_data   <= '0;
      fmt_start  <= 1'b0;
      fmt_end    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_gnt_q <= last_gnt_d;
      fmt_req    <= req_d;
      fmt_chid   <= chid_d;
      fmt_length <= len_d;
      fmt_valid  <= valid_d;
      fmt_data   <= data_d;
      fmt_start  <= start_d;
      fmt_end    <= end_d;
    end
  end

  // Next state; chid/length only change on IDLE exit so they stay frozen for the packet.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_gnt_d = last_gnt_q;
    req_d      = fmt_req;
    chid_d     = fmt_chid;
    len_d      = fmt_length;
    valid_d    = 1'b0;
    data_d     = fmt_data;
    start_d    = 1'b0;
    end_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = REQ;
          req_d   = 1'b1;
          chid_d  = pick_id;
          len_d   = next_len;
        end
      end
      REQ: begin
        if (fmt_grant) begin
          state_d = SEND;
          req_d   = 1'b0;
          beat_d  = '0;
        end
      end
      SEND: begin
        valid_d = 1'b1;
        data_d  = ch_data[fmt_chid*DATA_WIDTH +: DATA_WIDTH];
        start_d = (beat_q == '0);
        end_d   = last_beat;
        beat_d  = beat_q + CNT_W'(1);
        if (last_beat) begin
          last_gnt_d = fmt_chid;
          state_d    = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcdf_pkt_arbiter.sv
// Randomised and directed bench for mcdf_pkt_arbiter with a transaction-level reference model.
module tb_mcdf_pkt_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  ch_en = '0;
  logic [5:0]  ch_prio = '0;
  logic [1:0]  len_sel = '0;
  logic [17:0] ch_count = '0;
  logic [95:0] ch_data = '0;
  logic [2:0]  ch_rd;
  logic        fmt_grant = 1'b0;
  logic        fmt_req;
  logic [1:0]  fmt_chid;
  logic [5:0]  fmt_length;
  logic        fmt_valid;
  logic [31:0] fmt_data;
  logic        fmt_start;
  logic        fmt_end;

  mcdf_pkt_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_prio(ch_prio), .len_sel(len_sel),
    .ch_count(ch_count), .ch_data(ch_data), .ch_rd(ch_rd), .fmt_grant(fmt_grant),
    .fmt_req(fmt_req), .fmt_chid(fmt_chid), .fmt_length(fmt_length),
    .fmt_valid(fmt_valid), .fmt_data(fmt_data), .fmt_start(fmt_start), .fmt_end(fmt_end)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Channel FIFO model.
  logic [31:0] mem [3][8192];
  int wp [3];
  int rp [3];
  int fill_rate = 0;

  // Packet-level reference model.
  bit          m_busy, m_granted;
  int          m_ch, m_len, m_pops, m_vidx, m_last, m_since, m_pkts;
  logic [31:0] m_words [32];
  int          pick_log [$];

  // Pre-edge snapshot.
  logic       p_rst, p_req, p_grant;
  logic [2:0] p_rd, p_en;
  logic [5:0] p_prio;
  logic [1:0] p_len;
  int         p_cnt [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    for (int c = 0; c < 3; c++) begin
      ch_count[6*c +: 6] = 6'(wp[c] - rp[c]);
      ch_data[32*c +: 32] = (wp[c] > rp[c]) ? mem[c][rp[c]] : 32'h0;
    end
  endtask

  task automatic push(input int c);
    if (wp[c] - rp[c] < 32 && wp[c] < 8192) begin
      mem[c][wp[c]] = $urandom;
      wp[c]++;
    end
  endtask

  task automatic fill_full();
    for (int c = 0; c < 3; c++)
      while (wp[c] - rp[c] < 32 && wp[c] < 8192) push(c);
    drive_fifo();
  endtask

  task automatic model_reset();
    m_busy = 0; m_granted = 0; m_pops = 0; m_vidx = 0;
    m_last = 2; m_since = 2;
  endtask

  // Eligible = enabled and holding a full packet; lowest priority value wins,
  // ties go to the nearest channel after the last granted one.
  function automatic int model_pick(input int len);
    int best, c;
    best = 4;
    for (int i = 0; i < 3; i++)
      if (p_en[i] && p_cnt[i] >= len && int'(p_prio[2*i +: 2]) < best) best = int'(p_prio[2*i +: 2]);
    for (int d = 1; d <= 3; d++) begin
      c = (m_last + d) % 3;
      if (p_en[c] && p_cnt[c] >= len && int'(p_prio[2*c +: 2]) == best) return c;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 64'(fmt_req), 64'd0);
    check({tag, "_chid"}, 64'(fmt_chid), 64'd0);
    check({tag, "_len"}, 64'(fmt_length), 64'd0);
    check({tag, "_valid"}, 64'(fmt_valid), 64'd0);
    check({tag, "_data"}, 64'(fmt_data), 64'd0);
    check({tag, "_start"}, 64'(fmt_start), 64'd0);
    check({tag, "_end"}, 64'(fmt_end), 64'd0);
    check({tag, "_rd"}, 64'(ch_rd), 64'd0);
  endtask

  // One clock: snapshot at negedge, advance at posedge, check against the model.
  task automatic step();
    logic [2:0] erd;
    bit ev;
    int pk, ln;
    @(negedge clk);
    p_rst = rst; p_req = fmt_req; p_grant = fmt_grant; p_rd = ch_rd;
    p_en = ch_en; p_prio = ch_prio; p_len = len_sel;
    for (int c = 0; c < 3; c++) p_cnt[c] = wp[c] - rp[c];
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++)
      if (p_rd[c] && rp[c] < wp[c]) rp[c]++;
    if (p_rst || rst) begin
      model_reset();
      if (rst) begin
        check("rst_req", 64'(fmt_req), 64'd0);
        check("rst_valid", 64'(fmt_valid), 64'd0);
      end
    end else begin
      if (m_since < 2) m_since++;
      erd = (m_busy && m_granted && m_pops < m_len) ? 3'(1 << m_ch) : 3'd0;
      check("ch_rd", 64'(p_rd), 64'(erd));
      ev = (erd != 3'd0);
      if (ev) m_pops++;
      check("fmt_valid", 64'(fmt_valid), 64'(ev));
      if (ev) begin
        check("fmt_data", 64'(fmt_data), 64'(m_words[m_vidx]));
        check("fmt_start", 64'(fmt_start), 64'(m_vidx == 0));
        check("fmt_end", 64'(fmt_end), 64'(m_vidx == m_len - 1));
        if (m_vidx == m_len - 1) begin
          m_busy = 0; m_last = m_ch; m_since = 0; m_pkts++;
        end
        m_vidx++;
      end
      if (m_busy && !m_granted) begin
        if (p_grant) begin
          m_granted = 1;
          check("req_drop", 64'(fmt_req), 64'd0);
        end else begin
          check("req_hold", 64'(fmt_req), 64'd1);
        end
      end else if (m_busy) begin
        check("req_send", 64'(fmt_req), 64'd0);
      end else begin
        ln = 4 * (2 ** int'(p_len));
        pk = (m_since >= 2) ? model_pick(ln) : -1;
        if (pk >= 0) begin
          m_busy = 1; m_granted = 0; m_pops = 0; m_vidx = 0;
          m_ch = pk; m_len = ln;
          for (int k = 0; k < ln; k++) m_words[k] = mem[pk][rp[pk] + k];
          pick_log.push_back(pk);
        end
        check("req_new", 64'(fmt_req), 64'(pk >= 0));
      end
      if (m_busy) begin
        check("fmt_chid", 64'(fmt_chid), 64'(m_ch));
        check("fmt_length", 64'(fmt_length), 64'(m_len));
      end
    end
    for (int c = 0; c < 3; c++)
      if ($urandom_range(99) < fill_rate) push(c);
    drive_fifo();
  endtask

  initial begin
    int n, saved, pk0;
    for (int c = 0; c < 3; c++) begin wp[c] = 0; rp[c] = 0; end
    model_reset();
    m_pkts = 0;
    drive_fifo();

    // Reset values
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single channel, 4-word packet, grant tied high
    ch_en = 3'b001; len_sel = 2'd0; fmt_grant = 1'b1; fill_rate = 0;
    for (int k = 0; k < 4; k++) push(0);
    drive_fifo();
    pick_log.delete();
    for (int k = 0; k < 15; k++) step();
    check("single_pkts", 64'(m_pkts), 64'd1);
    check("single_ch", 64'(pick_log.size() > 0 ? pick_log[0] : -1), 64'd0);
    check("single_empty", 64'(ch_count[5:0]), 64'd0);

    // Priority: ch2=0 beats ch0=1 and ch1=2 while ch2 stays full
    ch_en = 3'b111; ch_prio = {2'd0, 2'd2, 2'd1}; fill_rate = 100;
    fill_full();
    pick_log.delete();
    for (int k = 0; k < 40; k++) step();
    check("prio_n", 64'(pick_log.size() >= 3), 64'd1);
    for (int k = 0; k < 3; k++)
      check("prio_ch", 64'(pick_log.size() > k ? pick_log[k] : -1), 64'd2);

    // Round-robin tie among equal priorities
    ch_prio = 6'd0;
    pick_log.delete();
    n = 0;
    while (pick_log.size() < 4 && n < 200) begin step(); n++; end
    check("rr_timeout", 64'(pick_log.size() >= 4), 64'd1);
    for (int k = 0; k < 4; k++)
      check("rr_ch", 64'(pick_log.size() > k ? pick_log[k] : -1), 64'(k % 3));

    // Grant stall
    fmt_grant = 1'b0;
    n = 0;
    while (!fmt_req && n < 80) begin step(); n++; end
    check("stall_req_seen", 64'(fmt_req), 64'd1);
    saved = int'(fmt_chid);
    for (int k = 0; k < 10; k++) begin
      step();
      check("stall_req", 64'(fmt_req), 64'd1);
      check("stall_chid", 64'(fmt_chid), 64'(saved));
      check("stall_len", 64'(fmt_length), 64'd4);
      check("stall_rd", 64'(ch_rd), 64'd0);
    end
    fmt_grant = 1'b1;
    step();
    check("stall_drop", 64'(fmt_req), 64'd0);
    check("stall_send", 64'(ch_rd), 64'(3'(1 << saved)));

    // Length change mid-packet only affects the next pick
    len_sel = 2'd1;
    n = 0;
    while (!(m_busy && m_granted && m_len == 8) && n < 200) begin step(); n++; end
    check("cfg_wait", 64'(m_busy && m_granted && m_len == 8), 64'd1);
    len_sel = 2'd3;
    step();
    check("cfg_len_hold", 64'(fmt_length), 64'd8);
    pk0 = m_pkts;
    n = 0;
    while (!(m_pkts > pk0 && m_busy) && n < 200) begin step(); n++; end
    check("cfg_next", 64'(m_pkts > pk0 && m_busy), 64'd1);
    check("cfg_len_next", 64'(fmt_length), 64'd32);

    // Asynchronous reset during word 3 of an 8-word packet
    n = 0;
    while (m_busy && n < 200) begin step(); n++; end
    len_sel = 2'd1;
    n = 0;
    while (!(m_busy && m_len == 8 && m_vidx == 3) && n < 300) begin step(); n++; end
    check("mid_wait", 64'(m_vidx == 3 && fmt_valid), 64'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    step(); step();
    rst = 1'b0;
    fill_full();
    pick_log.delete();
    n = 0;
    while (pick_log.size() == 0 && n < 20) begin step(); n++; end
    check("midrst_first", 64'(pick_log.size() > 0 ? pick_log[0] : -1), 64'd0);
    check("midrst_chid", 64'(fmt_chid), 64'd0);

    // Randomised traffic
    for (int k = 0; k < 2500; k++) begin
      if (k % 40 == 0) begin
        ch_en = 3'($urandom); ch_prio = 6'($urandom); len_sel = 2'($urandom);
        fill_rate = $urandom_range(100, 20);
      end
      fmt_grant = ($urandom_range(3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
